// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the program ROM read port between CPU fetch and a burst reader.
// CPU has priority; after STARVE_LIMIT back-to-back CPU wins, the next slot goes to the burst.
module rom_fetch_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic [6:0] cpu_addr,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dma_start,
    input  logic [6:0] dma_addr,
    input  logic [7:0] dma_len,
    output logic       dma_busy,
    output logic       dma_rvalid,
    output logic [7:0] dma_rdata,
    output logic       dma_done,
    output logic [6:0] rom_address,
    input  logic [7:0] rom_data_in
);
    // state | meaning
    // IDLE  | no burst running; waiting for dma_start
    // BURST | burst eligible for the ROM port every cycle
    // FLUSH | last burst byte returns; dma_done pulses
    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DMA} tag_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    tag_t       tag, tag_nxt;
    logic [6:0] baddr, baddr_nxt;
    logic [7:0] remaining, remaining_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       dma_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tag        <= TAG_NONE;
            baddr      <= '0;
            remaining  <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tag        <= tag_nxt;
            baddr      <= baddr_nxt;
            remaining  <= remaining_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        baddr_nxt     = baddr;
        remaining_nxt = remaining;
        starve_nxt    = starve_cnt;
        tag_nxt       = TAG_NONE;
        dma_gnt       = 1'b0;
        cpu_gnt       = 1'b0;
        rom_address   = '0;

        if (!reset) begin
            dma_gnt     = (state == BURST) && (!cpu_req || starve_cnt == LIMIT);
            cpu_gnt     = cpu_req && !dma_gnt;
            rom_address = dma_gnt ? baddr : cpu_addr;
            if (dma_gnt)
                tag_nxt = TAG_DMA;
            else if (cpu_gnt)
                tag_nxt = TAG_CPU;
        end

        case (state)
            IDLE: begin
                starve_nxt = '0;
                if (dma_start) begin
                    if (dma_len == 8'd0) begin
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt     = BURST;
                        baddr_nxt     = dma_addr;
                        remaining_nxt = (dma_len > 8'd128) ? 8'd128 : dma_len;
                    end
                end
            end
            BURST: begin
                if (dma_gnt) begin
                    starve_nxt    = '0;
                    baddr_nxt     = baddr + 7'd1;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1)
                        state_nxt = FLUSH;
                end else if (cpu_gnt && starve_cnt != LIMIT) begin
                    starve_nxt = starve_cnt + 4'd1;
                end
            end
            FLUSH: begin
                starve_nxt = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Returns are gated by reset so a read tagged just before reset never surfaces.
    assign cpu_rvalid = !reset && (tag == TAG_CPU);
    assign dma_rvalid = !reset && (tag == TAG_DMA);
    assign cpu_rdata  = cpu_rvalid ? rom_data_in : 8'd0;
    assign dma_rdata  = dma_rvalid ? rom_data_in : 8'd0;
    assign dma_busy   = !reset && (state != IDLE);
    assign dma_done   = !reset && (state == FLUSH);

endmodule
